// File: rtl/alu_pkg.sv
// alu_pkg: function codes and FSM states shared by the multicycle ALU
package alu_pkg;
  typedef enum logic [2:0] {
    AND_F  = 3'b000,
    OR_F   = 3'b001,
    ADD_F  = 3'b010,
    MUL_F  = 3'b011,
    RSV4_F = 3'b100,
    RSV5_F = 3'b101,
    SUB_F  = 3'b110,
    SLT_F  = 3'b111
  } alufn_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath for logic ops, add/sub and overflow-corrected signed SLT
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  logic             sub, arith, c, v;
  logic [WIDTH-1:0] bb, s;
  assign sub   = f == SUB_F || f == SLT_F;
  assign arith = f == ADD_F || f == SUB_F;
  assign bb    = sub ? ~b : b;
  assign {c, s} = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
  assign v     = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  // reserved codes (and MUL when the multiplier is absent) fall through to zero
  assign y = f == AND_F ? a & b :
             f == OR_F  ? a | b :
             arith      ? s :
             f == SLT_F ? {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ v} : '0;
  assign cout = arith & c;
  assign ovf  = arith & v;
  assign zero = y == '0;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked registered ALU; define ALU_MUL_EN to add the WIDTH-cycle shift-add MUL
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  state_t           state;
  logic [WIDTH-1:0] cy;
  logic             cc, cv, cz;
  alu_core #(.WIDTH(WIDTH)) u_core (.a(a), .b(b), .f(f), .y(cy), .cout(cc), .ovf(cv), .zero(cz));
  assign in_ready  = !reset && state == IDLE;
  assign out_valid = state == DONE;
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand, mplier, acc, nacc;
  logic [CW-1:0]    cnt;
  assign nacc = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid && f == MUL_F) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= nacc;
      cnt    <= cnt + 1'b1;
    end
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      y     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
`ifdef ALU_MUL_EN
          if (f == MUL_F) state <= BUSY;
          else begin
`else
          begin
`endif
            y     <= cy;
            cout  <= cc;
            ovf   <= cv;
            zero  <= cz;
            state <= DONE;
          end
        end
`ifdef ALU_MUL_EN
        // the last shift-add step is folded into the latched result
        BUSY: if (cnt == CW'(WIDTH - 1)) begin
          y     <= nacc;
          cout  <= 1'b0;
          ovf   <= 1'b0;
          zero  <= nacc == '0;
          state <= DONE;
        end
`endif
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random ops checked against an arithmetic reference model
module tb_alu_mc;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  f = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] y;
  int vecs = 0, miss = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns {zero, ovf, cout, y}
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mf);
    longint unsigned ua = 64'(ma), ub = 64'(mb);
    longint sa = longint'($signed(ma)), sb = longint'($signed(mb));
    longint r;
    logic [31:0] ry = '0;
    logic rc = 1'b0, rv = 1'b0;
    case (mf)
      3'b000: ry = ma & mb;
      3'b001: ry = ma | mb;
      3'b010: begin
        ry = 32'(ua + ub);
        rc = (ua + ub) >= 64'h1_0000_0000;
        r = sa + sb;
        rv = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      3'b110: begin
        ry = 32'(ua - ub);
        rc = ua >= ub;
        r = sa - sb;
        rv = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      3'b111: ry = {31'b0, sa < sb};
`ifdef ALU_MUL_EN
      3'b011: ry = 32'(ua * ub);
`endif
      default: ry = '0;
    endcase
    return {ry == 32'h0, rv, rc, ry};
  endfunction

  task automatic run(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tf, input int hold, input bit present_or);
    logic [34:0] e = model(ta, tb_, tf);
    int lat = 1, n = 0, w = 0;
`ifdef ALU_MUL_EN
    if (tf == 3'b011) lat = 33;
`endif
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    a = ta; b = tb_; f = tf; in_valid = 1'b1; out_ready = 1'b0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin in_valid = 1'b0; a = $urandom; b = $urandom; f = 3'($urandom); end
      if (!out_valid) chk("busy_in_ready", {63'b0, in_ready}, 64'd0);
    end while (!out_valid && n < 100);
    chk("latency", 64'(n), 64'(lat));
    chk("y", {32'b0, y}, {32'b0, e[31:0]});
    chk("cout", {63'b0, cout}, {63'b0, e[32]});
    chk("ovf", {63'b0, ovf}, {63'b0, e[33]});
    chk("zero", {63'b0, zero}, {63'b0, e[34]});
    chk("done_in_ready", {63'b0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (present_or) begin in_valid = 1'b1; a = 32'b01011; b = 32'b00111; f = 3'b001; end
      chk("hold_y", {32'b0, y}, {32'b0, e[31:0]});
      chk("hold_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("taken_valid", {63'b0, out_valid}, 64'd0);
    chk("taken_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_y", {32'b0, y}, 64'd0);
    chk("rst_flags", {61'b0, cout, ovf, zero}, 64'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    run(32'd3, 32'd5, 3'b010, 0, 1'b0);
    run(32'h7FFFFFFF, 32'd1, 3'b010, 0, 1'b0);
    run(32'h80000000, 32'h80000000, 3'b010, 0, 1'b0);
    run(32'h80000000, 32'd1, 3'b111, 0, 1'b0);
    run(32'd32, 32'd31, 3'b111, 0, 1'b0);
    run(32'd31, 32'd40, 3'b111, 0, 1'b0);
    run(32'd12, 32'd24, 3'b110, 0, 1'b0);
    run(32'b01011, 32'b00111, 3'b000, 5, 1'b1);
    run(32'b01011, 32'b00111, 3'b001, 0, 1'b0);
    run(32'd12, 32'hFFFFFFFD, 3'b011, 1, 1'b0);
    run(32'd0, 32'hFFFFFFFF, 3'b011, 0, 1'b0);
    run(32'h1234, 32'h5678, 3'b100, 0, 1'b0);
    run(32'h1234, 32'h5678, 3'b101, 0, 1'b0);
    run(32'h5, 32'h5, 3'b110, 0, 1'b0);
    @(negedge clk);
    a = 32'd5; b = 32'd7; f = 3'b011; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_y", {32'b0, y}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk) reset = 1'b0;
    run(32'd1, 32'd1, 3'b010, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra = $urandom, rb = $urandom;
      if (i % 5 == 1) rb = ra;
      if (i % 7 == 2) ra = 32'h80000000;
      run(ra, rb, 3'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
